// File: rtl/sp_pkg.sv
// Shared types for the SIMD lane array: opcodes, ALU functions, operand-B selects, sequencer states.
// Pure type package, no logic and no latency.
// Not applicable to backpressure; consumers use these encodings on their handshakes.
package sp_pkg;
    typedef enum logic [1:0] {OP_ALU = 2'd0, OP_LOAD = 2'd1, OP_STORE = 2'd2, OP_NOP = 2'd3} op_e;
    typedef enum logic [3:0] {
        ADD = 4'd0, SUB, AND, OR, XOR, SHL, SHR, MUL, CMP_EQ, CMP_LTU
    } aluc_e;
    typedef enum logic [1:0] {S2_REG = 2'd0, S2_IMM, S2_LANE, S2_NLANES} s2_e;
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN, REQ, RESP} state_e;
endpackage

// File: rtl/sp_lane.sv
// One SIMD lane: register file, single-cycle ALU, predicate flop and a load write-back port.
// ALU results land in the register file at the issuing edge; reads are combinational.
// No backpressure of its own; the array only asserts alu_en/ld_we when a write may happen.
module sp_lane
    import sp_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_N   = 16,
    parameter int LANE_ID = 0,
    parameter int N_LANES = 4,
    localparam int RIDX_W = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_en,
    input  logic [RIDX_W-1:0] rx,
    input  logic [RIDX_W-1:0] ry,
    input  logic [RIDX_W-1:0] wz,
    input  logic [DATA_W-1:0] imm,
    input  logic [3:0]        aluc,
    input  logic [1:0]        s2,
    input  logic              reg_we,
    input  logic              ld_we,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] rd_x,
    output logic [DATA_W-1:0] rd_y,
    output logic              p
);
    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] rf [REG_N];
    logic [DATA_W-1:0] a, b, res;
    logic              res_wr, is_cmp, cmp;

    assign a    = rf[rx];
    assign rd_x = a;
    assign rd_y = rf[ry];

    always_comb begin
        b      = rf[ry];
        res    = '0;
        res_wr = 1'b1;
        is_cmp = 1'b0;
        cmp    = 1'b0;
        case (s2_e'(s2))
            S2_IMM:    b = imm;
            S2_LANE:   b = DATA_W'(LANE_ID);
            S2_NLANES: b = DATA_W'(N_LANES);
            default:   b = rf[ry];
        endcase
        case (aluc_e'(aluc))
            ADD:     res = a + b;
            SUB:     res = a - b;
            AND:     res = a & b;
            OR:      res = a | b;
            XOR:     res = a ^ b;
            SHL:     res = a << b[SH_W-1:0];
            SHR:     res = a >> b[SH_W-1:0];
            MUL:     res = a * b;
            CMP_EQ:  begin res_wr = 1'b0; is_cmp = 1'b1; cmp = (a == b); end
            CMP_LTU: begin res_wr = 1'b0; is_cmp = 1'b1; cmp = (a < b);  end
            default: res_wr = 1'b0;
        endcase
    end

    // ALU writes only happen while the array is idle and load writes only in RESP, so wz never collides.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < REG_N; r++) rf[r] <= '0;
            p <= 1'b0;
        end else begin
            if (alu_en && res_wr && reg_we) rf[wz] <= res;
            if (alu_en && is_cmp) p <= cmp;
            if (ld_we) rf[wz] <= ld_data;
        end
    end
endmodule

// File: rtl/sp_lane_array.sv
// N_LANES SIMD lane array: broadcast ALU ops, lane-serialised LOAD/STORE on one memory port (perf counters with SP_LANE_ARRAY_PERF_CNT_EN).
// ALU ops complete at the accept edge; memory ops take at least SCAN+REQ(+RESP) cycles per enabled lane.
// instr_ready only while idle; a request holds address/data until mem_gnt, a load then waits for mem_rvalid.
module sp_lane_array
    import sp_pkg::*;
#(
    parameter int N_LANES = 4,
    parameter int DATA_W  = 16,
    parameter int REG_N   = 16,
    parameter int ADDR_W  = 16,
    localparam int RIDX_W = $clog2(REG_N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [1:0]         instr_op,
    input  logic [RIDX_W-1:0]  x,
    input  logic [RIDX_W-1:0]  y,
    input  logic [RIDX_W-1:0]  z,
    input  logic [DATA_W-1:0]  imm,
    input  logic [3:0]         aluc,
    input  logic [1:0]         s2,
    input  logic               reg_we,
    input  logic [N_LANES-1:0] en,
    output logic [N_LANES-1:0] p,
    output logic               busy,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [DATA_W-1:0]  mem_rdata
`ifdef SP_LANE_ARRAY_PERF_CNT_EN
    ,
    output logic [31:0]        perf_busy_cyc,
    output logic [31:0]        perf_mem_ops
`endif
);
    localparam int LIDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    state_e              state, state_nx;
    op_e                 op_q;
    logic [RIDX_W-1:0]   x_q, y_q, z_q, rx, ry, wz;
    logic [DATA_W-1:0]   imm_q, addr_sum;
    logic [N_LANES-1:0]  pend_q, alu_en, ld_we;
    logic [LIDX_W-1:0]   cur_q, pick;
    logic                found, accept, mem_acc;
    logic [DATA_W-1:0]   lane_x [N_LANES];
    logic [DATA_W-1:0]   lane_y [N_LANES];

    assign instr_ready = (state == IDLE);
    assign accept      = instr_valid && instr_ready;
    assign mem_acc     = accept && (op_e'(instr_op) == OP_LOAD || op_e'(instr_op) == OP_STORE);

    // Lanes read the live instruction while idle and the latched one during a memory sequence.
    assign rx = (state == IDLE) ? x : x_q;
    assign ry = (state == IDLE) ? y : y_q;
    assign wz = (state == IDLE) ? z : z_q;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        assign alu_en[i] = accept && (op_e'(instr_op) == OP_ALU) && en[i];
        assign ld_we[i]  = (state == RESP) && mem_rvalid && (cur_q == LIDX_W'(i));
        sp_lane #(.DATA_W(DATA_W), .REG_N(REG_N), .LANE_ID(i), .N_LANES(N_LANES)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .alu_en  (alu_en[i]),
            .rx      (rx),
            .ry      (ry),
            .wz      (wz),
            .imm     (imm),
            .aluc    (aluc),
            .s2      (s2),
            .reg_we  (reg_we),
            .ld_we   (ld_we[i]),
            .ld_data (mem_rdata),
            .rd_x    (lane_x[i]),
            .rd_y    (lane_y[i]),
            .p       (p[i])
        );
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                found = 1'b1;
                pick  = LIDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (mem_acc) state_nx = SCAN;
            end
            SCAN: state_nx = found ? REQ : IDLE;
            REQ: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OP_STORE);
                if (mem_gnt) state_nx = (op_q == OP_LOAD) ? RESP : SCAN;
            end
            RESP: if (mem_rvalid) state_nx = SCAN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            op_q   <= OP_NOP;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            imm_q  <= '0;
            pend_q <= '0;
            cur_q  <= '0;
        end else begin
            state <= state_nx;
            if (mem_acc) begin
                op_q   <= op_e'(instr_op);
                x_q    <= x;
                y_q    <= y;
                z_q    <= z;
                imm_q  <= imm;
                pend_q <= en;
            end
            if (state == SCAN && found) begin
                cur_q        <= pick;
                pend_q[pick] <= 1'b0;
            end
        end
    end

    assign addr_sum  = lane_x[cur_q] + imm_q;
    assign mem_addr  = ADDR_W'(addr_sum);
    assign mem_wdata = mem_we ? lane_y[cur_q] : '0;

`ifdef SP_LANE_ARRAY_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_busy_cyc <= '0;
            perf_mem_ops  <= '0;
        end else begin
            if (busy && perf_busy_cyc != '1) perf_busy_cyc <= perf_busy_cyc + 32'd1;
            if (mem_req && mem_gnt && perf_mem_ops != '1) perf_mem_ops <= perf_mem_ops + 32'd1;
        end
    end
`else
    // Counters are absent in this build.
`endif
endmodule
